// File: rtl/hamming_frame_receiver_pkg.sv
// ----------------------------------------------------------------------------
// hamming_frame_receiver_pkg
//   Shared definitions for the inter-controller Hamming frame receiver:
//   receiver FSM state encoding, serial line levels, and the BYTES/LENG
//   derivation shared with the SerialHammingEncoder/Decoder stages.
//   No ports (package).
// ----------------------------------------------------------------------------
package hamming_frame_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP,
        ST_FLUSH
    } rx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Each serial byte carries one Hamming(7,4) codeword plus a pad bit, so
    // one byte per started nibble of payload.
    function automatic int calc_bytes(input int n);
        return n / 4 + (((n % 4) != 0) ? 1 : 0);
    endfunction

    function automatic int calc_leng(input int n);
        return 8 * calc_bytes(n);
    endfunction

endpackage

// File: rtl/hamming_frame_receiver_rx_bit_sampler.sv
// ----------------------------------------------------------------------------
// hamming_frame_receiver_rx_bit_sampler
//   Two-flop synchronizer for the asynchronous serial line plus the baud
//   counter that places sample points.
//
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     rx        in   raw serial line (idle high, asynchronous to clk)
//     restart   in   hold the baud counter at zero (no strobe while high)
//     half_bit  in   1: strobe after CLKS_PER_BIT/2 cycles (start-bit centre)
//                    0: strobe after CLKS_PER_BIT cycles (next bit centre)
//     rx_s      out  synchronized serial line
//     sample    out  one-cycle strobe marking a sample point
// ----------------------------------------------------------------------------
module hamming_frame_receiver_rx_bit_sampler
    import hamming_frame_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic restart,
    input  logic half_bit,
    output logic rx_s,
    output logic sample
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT - 1) + 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic [CNT_W-1:0] baud_cnt;

    // Synchronizer resets to the idle line level so reset never looks like
    // a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign sample = !restart && (baud_cnt == (half_bit ? HALF_LAST : FULL_LAST));

    // Counter restarts on every strobe, so consecutive strobes are exactly
    // one bit-time apart once the half-bit offset has been applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (restart || sample) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hamming_frame_receiver.sv
// ----------------------------------------------------------------------------
// hamming_frame_receiver
//   UART-style receiver for the elevator inter-controller link. Collects
//   BYTES Hamming-coded bytes (start 0, 8 data LSB first, stop 1) into one
//   frame laid out as the SerialHammingEncoder produces it: the first byte
//   received lands in the top byte of frame_data. Data bit 0 of every byte
//   is a pad bit that must be 0. Stalled frames are aborted after
//   TIMEOUT_BITS idle bit-times between bytes.
//   CLKS_PER_BIT must be even and at least 4.
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     rx           in   serial line, idle high, asynchronous to clk
//     frame_data   out  last good frame (LENG bits)
//     frame_valid  out  one-cycle pulse, frame_data was updated
//     frame_err    out  one-cycle pulse, a frame was discarded
//     busy         out  high from a validated start bit until frame end/abort
// ----------------------------------------------------------------------------
module hamming_frame_receiver
    import hamming_frame_receiver_pkg::*;
#(
    parameter  int N            = 8,
    parameter  int CLKS_PER_BIT = 16,
    parameter  int TIMEOUT_BITS = 20,
    localparam int LENG         = calc_leng(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    output logic [LENG-1:0] frame_data,
    output logic            frame_valid,
    output logic            frame_err,
    output logic            busy
);

    localparam int BYTES          = calc_bytes(N);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;

    localparam int BIT_CNT_W  = $clog2(7) + 1;
    localparam int BYTE_CNT_W = $clog2(BYTES - 1) + 1;
    localparam int TMO_CNT_W  = $clog2(TIMEOUT_CYCLES - 1) + 1;

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(7);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES - 1);
    localparam logic [TMO_CNT_W-1:0]  LAST_TMO  = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    rx_state_t             state;
    logic                  from_gap;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [TMO_CNT_W-1:0]  timeout_cnt;
    logic [7:0]            shift_reg;
    logic [LENG-1:0]       partial_buf;
    logic [LENG-1:0]       assembled;
    logic                  pad_err;

    logic rx_s;
    logic sample;
    logic sampler_restart;
    logic half_bit;

    // The baud counter only runs while a bit is being timed. In FLUSH it
    // restarts on every low level so it strobes after one full high bit-time.
    assign sampler_restart = (state == ST_IDLE) || (state == ST_GAP) ||
                             ((state == ST_FLUSH) && (rx_s != STOP_LEVEL));
    assign half_bit        = (state == ST_START);

    hamming_frame_receiver_rx_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_bit_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .restart  (sampler_restart),
        .half_bit (half_bit),
        .rx_s     (rx_s),
        .sample   (sample)
    );

    // Earlier bytes shift up by one byte each time a byte completes, so the
    // first byte received ends up in the most significant byte.
    always_comb begin
        assembled = (partial_buf << 8) | LENG'(shift_reg);
    end

    // Receiver FSM. Every exit that ends or abandons a frame wipes the byte
    // counter, pad error flag and partial data so nothing leaks into the
    // next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            from_gap    <= 1'b0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
            shift_reg   <= '0;
            partial_buf <= '0;
            pad_err     <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state    <= ST_START;
                        from_gap <= 1'b0;
                        bit_cnt  <= '0;
                    end
                end

                // A start bit that is gone by mid-bit was a glitch; fall back
                // to the caller with its counters untouched.
                ST_START: begin
                    if (sample) begin
                        if (rx_s == START_LEVEL) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end else begin
                            state <= from_gap ? ST_GAP : ST_IDLE;
                        end
                    end
                end

                ST_DATA: begin
                    if (sample) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if ((bit_cnt == '0) && (rx_s == 1'b1)) begin
                            pad_err <= 1'b1;
                        end
                        if (bit_cnt == LAST_BIT) begin
                            state   <= ST_STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (sample) begin
                        if (rx_s != STOP_LEVEL) begin
                            frame_err   <= 1'b1;
                            busy        <= 1'b0;
                            byte_cnt    <= '0;
                            pad_err     <= 1'b0;
                            shift_reg   <= '0;
                            partial_buf <= '0;
                            state       <= ST_FLUSH;
                        end else if (byte_cnt == LAST_BYTE) begin
                            if (pad_err) begin
                                frame_err <= 1'b1;
                            end else begin
                                frame_data  <= assembled;
                                frame_valid <= 1'b1;
                            end
                            busy        <= 1'b0;
                            byte_cnt    <= '0;
                            pad_err     <= 1'b0;
                            shift_reg   <= '0;
                            partial_buf <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            partial_buf <= assembled;
                            byte_cnt    <= byte_cnt + BYTE_CNT_W'(1);
                            timeout_cnt <= '0;
                            state       <= ST_GAP;
                        end
                    end
                end

                // A start bit takes priority over the timeout on the same cycle.
                ST_GAP: begin
                    if (rx_s == START_LEVEL) begin
                        state    <= ST_START;
                        from_gap <= 1'b1;
                        bit_cnt  <= '0;
                    end else if (timeout_cnt == LAST_TMO) begin
                        frame_err   <= 1'b1;
                        busy        <= 1'b0;
                        byte_cnt    <= '0;
                        pad_err     <= 1'b0;
                        shift_reg   <= '0;
                        partial_buf <= '0;
                        timeout_cnt <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TMO_CNT_W'(1);
                    end
                end

                // Wait out a broken byte until the line has been idle for a
                // whole bit-time, so its tail is not taken as a new start bit.
                ST_FLUSH: begin
                    if (sample) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
